instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter MEMORY_WIDTH, default 8: width in bits of one storage location (byte).
REQ-002 Parameter MEMORY_DEPTH, default 64: number of byte locations; power of two.
REQ-003 Parameter NB_ADDR, default 32: read address width.
REQ-004 Parameter NB_INSTRUCTION, default 32: instruction width; equals 4*MEMORY_WIDTH.
REQ-005 Port i_clock  input  1  single clock; all state changes on the rising edge.
REQ-006 Port i_reset  input  1  reset, synchronous, active-high.
REQ-007 Port i_read_enable  input  1  registers a new instruction into o_read_data when high.
REQ-008 Port i_write_enable  input  1  writes i_write_data at the internal write pointer when high (debug-unit load path).
REQ-009 Port i_write_data  input  MEMORY_WIDTH  byte to store.
REQ-010 Port i_read_addr  input  NB_ADDR  byte address of the instruction to read.
REQ-011 Port o_read_data  output  NB_INSTRUCTION  registered instruction word.

Function
REQ-012 Storage SHALL be MEMORY_DEPTH locations of MEMORY_WIDTH bits.
REQ-013 Byte index SHALL be i_read_addr modulo MEMORY_DEPTH; upper address bits ignored.
REQ-014 On a rising edge with i_read_enable=1 and i_reset=0, o_read_data SHALL load {mem[a], mem[a+1], mem[a+2], mem[a+3]} (big-endian: mem[a] in bits 31:24), indices modulo MEMORY_DEPTH; latency one cycle.
REQ-015 Unaligned addresses SHALL be served identically per REQ-014; no alignment check.
REQ-016 With i_read_enable=0, o_read_data SHALL hold its previous value.
REQ-017 On a rising edge with i_write_enable=1 and i_reset=0, mem[wr_ptr] SHALL take i_write_data and wr_ptr SHALL increment by one, wrapping from MEMORY_DEPTH-1 to 0.
REQ-018 wr_ptr SHALL be an internal log2(MEMORY_DEPTH)-bit counter, initial value 0.
REQ-019 Simultaneous read and write SHALL be allowed; the read SHALL return contents before that edge's write (read-before-write).
REQ-020 With both enables low, memory, wr_ptr and o_read_data SHALL be unchanged.

Reset
REQ-021 i_reset=1 at a rising edge SHALL clear o_read_data to 0 and wr_ptr to 0.
REQ-022 Reset SHALL take priority over read and write; no write occurs on a reset edge.
REQ-023 Reset SHALL NOT alter memory contents; a program loaded before reset survives it.
REQ-024 Reset asserted mid-load SHALL restart loading at byte 0 on the next write.

Configuration
REQ-025 Macro INSTRUCTION_MEMORY_PRELOAD_EN: when defined, memory SHALL initialise at time zero with bytes 0..15 = words 0x20010005, 0x20020003, 0x00221820, 0xAC030000 (big-endian) and all other bytes 0; when undefined, all bytes SHALL initialise to 0.
REQ-026 Both builds SHALL be synthesizable; preload uses initial contents only, no extra logic.

Verification
REQ-027 Preload build, reset, then read_enable=1 with addr 0,4,8,12 held 2 cycles each -> o_read_data 0x20010005, 0x20020003, 0x00221820, 0xAC030000, each valid one edge after the address is applied.
REQ-028 Preload build, read addr 12, then read_enable=0 and addr changed to 0 -> o_read_data stays 0xAC030000.
REQ-029 Non-preload build, reset, write bytes 0xDE,0xAD,0xBE,0xEF, read addr 0 -> 0xDEADBEEF; read addr 1 -> 0xADBEEF00.
REQ-030 Write 66 bytes 0x00..0x41 -> bytes 0,1 hold 0x40,0x41 (pointer wrap); read addr 62 -> 0x3E3F4041; read addr 64 -> same as addr 0, 0x40410203.
REQ-031 Write 2 bytes, assert i_reset for one cycle with i_write_enable=1 -> o_read_data=0, no write on the reset edge; next write lands at byte 0; earlier contents of bytes 2..63 unchanged.
REQ-032 Same-edge write of 0x55 to byte 0 and read of addr 0 -> read returns old word; next read shows 0x55 in bits 31:24.

Source files
------------

// File: rtl/instruction_memory.sv
// Byte-addressed instruction store: serial byte load, 32-bit big-endian registered read; define INSTRUCTION_MEMORY_PRELOAD_EN for a built-in test program.
// Read latency one cycle; no backpressure, the write port accepts one byte per enabled edge.
module instruction_memory #(
  parameter int MEMORY_WIDTH   = 8,
  parameter int MEMORY_DEPTH   = 64,
  parameter int NB_ADDR        = 32,
  parameter int NB_INSTRUCTION = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_read_enable,
  input  logic                      i_write_enable,
  input  logic [MEMORY_WIDTH-1:0]   i_write_data,
  input  logic [NB_ADDR-1:0]        i_read_addr,
  output logic [NB_INSTRUCTION-1:0] o_read_data
);

  localparam int NB_PTR = $clog2(MEMORY_DEPTH);

  typedef logic [MEMORY_DEPTH-1:0][MEMORY_WIDTH-1:0] mem_image_t;

  function automatic mem_image_t f_init_image();
    mem_image_t  img;
    logic [127:0] prog;
    img  = '0;
    prog = 128'h20010005_20020003_00221820_AC030000;
`ifdef INSTRUCTION_MEMORY_PRELOAD_EN
    for (int i = 0; i < 16; i++) begin
      if (i < MEMORY_DEPTH) img[i] = MEMORY_WIDTH'(prog[127-8*i -: 8]);
    end
`else
    prog = '0;
`endif
    return img;
  endfunction

  localparam mem_image_t INIT_IMAGE = f_init_image();

  mem_image_t                 r_mem = INIT_IMAGE;
  logic [NB_PTR-1:0]          r_wr_ptr;
  logic [NB_INSTRUCTION-1:0]  r_read_data;

  logic [NB_PTR-1:0]          w_idx0;
  logic [NB_PTR-1:0]          w_idx1;
  logic [NB_PTR-1:0]          w_idx2;
  logic [NB_PTR-1:0]          w_idx3;
  logic [NB_INSTRUCTION-1:0]  w_word;
  logic                       w_unused_addr_hi;

  // Index arithmetic is NB_PTR bits wide, so a word straddling the top wraps to byte 0.
  assign w_idx0 = i_read_addr[NB_PTR-1:0];
  assign w_idx1 = w_idx0 + NB_PTR'(1);
  assign w_idx2 = w_idx0 + NB_PTR'(2);
  assign w_idx3 = w_idx0 + NB_PTR'(3);
  assign w_word = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};

  assign w_unused_addr_hi = ^i_read_addr[NB_ADDR-1:NB_PTR];

  always_ff @(posedge i_clock) begin
    if (!i_reset && i_write_enable) begin
      r_mem[r_wr_ptr] <= i_write_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_read_data <= '0;
      r_wr_ptr    <= '0;
    end else begin
      if (i_read_enable) begin
        r_read_data <= w_word;
      end
      if (i_write_enable) begin
        r_wr_ptr <= r_wr_ptr + NB_PTR'(1);
      end
    end
  end

  assign o_read_data = r_read_data;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: load, wrap, unaligned reads, read-before-write, reset behaviour.
module tb_instruction_memory;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [7:0]  wdat;
  logic [31:0] addr;
  logic [31:0] rdat;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef INSTRUCTION_MEMORY_PRELOAD_EN
  localparam logic [31:0] WORD1 = 32'h20020003;
`else
  localparam logic [31:0] WORD1 = 32'h00000000;
`endif

  instruction_memory #(
    .MEMORY_WIDTH  (8),
    .MEMORY_DEPTH  (64),
    .NB_ADDR       (32),
    .NB_INSTRUCTION(32)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_read_enable (re),
    .i_write_enable(we),
    .i_write_data  (wdat),
    .i_read_addr   (addr),
    .o_read_data   (rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    n_tests++;
    assert (rdat === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, rdat, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    we = 1'b1; re = 1'b0; wdat = b;
    tick();
    we = 1'b0;
  endtask

  task automatic read_at(input logic [31:0] a);
    re = 1'b1; we = 1'b0; addr = a;
    tick();
    re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; wdat = 8'h00; addr = 32'h0;
    tick();
    check("reset_clears_output", 32'h0);
    rst = 1'b0;

`ifdef INSTRUCTION_MEMORY_PRELOAD_EN
    re = 1'b1;
    addr = 32'd0;  tick(); check("preload_w0_a", 32'h20010005); tick(); check("preload_w0_b", 32'h20010005);
    addr = 32'd4;  tick(); check("preload_w1_a", 32'h20020003); tick(); check("preload_w1_b", 32'h20020003);
    addr = 32'd8;  tick(); check("preload_w2_a", 32'h00221820); tick(); check("preload_w2_b", 32'h00221820);
    addr = 32'd12; tick(); check("preload_w3_a", 32'hAC030000); tick(); check("preload_w3_b", 32'hAC030000);
    re = 1'b0; addr = 32'd0;
    tick(); check("preload_hold", 32'hAC030000);
`else
    read_at(32'd8);
    check("init_zero", 32'h0);
`endif

    // Load DE AD BE EF into bytes 0..3 and read aligned, unaligned and wrapped.
    write_byte(8'hDE); write_byte(8'hAD); write_byte(8'hBE); write_byte(8'hEF);
    read_at(32'd0);           check("load_word0", 32'hDEADBEEF);
    read_at(32'd1);           check("unaligned_1", {24'hADBEEF, WORD1[31:24]});
    read_at(32'd63);          check("wrap_read_63", 32'h00DEADBE);
    read_at(32'h1000_0040);   check("upper_addr_ignored", 32'hDEADBEEF);
    addr = 32'd1;
    tick();                   check("hold_both_low", 32'hDEADBEEF);

    // Reset with write enabled: output clears, nothing written at pointer 4.
    rst = 1'b1; we = 1'b1; wdat = 8'h99;
    tick();                   check("reset_with_write", 32'h0);
    rst = 1'b0;
    re = 1'b1; we = 1'b1; wdat = 8'h55; addr = 32'd0;
    tick();                   check("read_before_write", 32'hDEADBEEF);
    we = 1'b0;
    tick();                   check("write_visible_next", 32'h55ADBEEF);
    read_at(32'd4);           check("no_write_on_reset", WORD1);

    // 66 writes from a reset pointer wrap onto bytes 0 and 1.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 66; i++) write_byte(8'(i));
    read_at(32'd62);          check("wrap_addr_62", 32'h3E3F4041);
    read_at(32'd64);          check("addr_64_eq_0", 32'h40410203);
    read_at(32'd0);           check("addr_0", 32'h40410203);
    read_at(32'd63);          check("addr_63_wrap", 32'h3F404102);

    // Reset mid-load restarts the pointer at 0 and leaves other bytes intact.
    rst = 1'b1; tick(); rst = 1'b0;
    write_byte(8'hAA); write_byte(8'hBB);
    rst = 1'b1; we = 1'b1; wdat = 8'hCC;
    tick();                   check("midload_reset_out", 32'h0);
    rst = 1'b0; we = 1'b0;
    write_byte(8'h11);
    read_at(32'd0);           check("restart_at_byte0", 32'h11BB0203);
    read_at(32'd2);           check("bytes_2_5_kept", 32'h02030405);
    read_at(32'd32);          check("bytes_32_35_kept", 32'h20212223);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
